// File: rtl/ifm_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifm_reader_pkg
//  Description : Shared constants, FSM state encoding and helpers for the
//                IFM read path (ifm_reader, ifm_rd_fifo).
//  Revision    : 1.0  initial release
// ============================================================================
package ifm_reader_pkg;

    localparam int c_WORD_BYTE_DEF = 64;
    localparam int c_DATA_W        = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_REQ   = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage : ifm_reader_pkg
`default_nettype wire

// File: rtl/ifm_rd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ifm_rd_fifo
//  Description : First-word fall-through FIFO buffering stream words between
//                the read master and the IFM port.
//  Revision    : 1.0  initial release
// ============================================================================
module ifm_rd_fifo
    import ifm_reader_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W,
    parameter int ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_W-1:0]    push_data,
    input  logic                 pop,
    output logic [DATA_W-1:0]    head_data,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   data_cnt
);

    localparam int c_DEPTH = 2 ** ADDR_BITS;

    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [ADDR_BITS:0] r_wr_ptr;
    logic [ADDR_BITS:0] r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[ADDR_BITS] != r_rd_ptr[ADDR_BITS]) &&
                       (r_wr_ptr[ADDR_BITS-1:0] == r_rd_ptr[ADDR_BITS-1:0]);
    assign data_cnt  = r_wr_ptr - r_rd_ptr;
    assign head_data = r_mem[r_rd_ptr[ADDR_BITS-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule : ifm_rd_fifo
`default_nettype wire

// File: rtl/ifm_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ifm_reader
//  Description : Fetches a contiguous region of 512-bit words through the
//                read master and streams them to the IFM port via a FWFT FIFO.
//                Optional macro IFM_READER_BEAT_CHECK_EN enables the sticky
//                per-request beat-count check driving rd_err.
//  Revision    : 1.0  initial release
// ============================================================================
module ifm_reader
    import ifm_reader_pkg::*;
#(
    parameter int WORD_BYTE      = c_WORD_BYTE_DEF,
    parameter int BURST_WORDS    = 2,
    parameter int FIFO_ADDR_BITS = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_fetch,
    input  logic [63:0]         rmst_offset,
    input  logic [31:0]         total_words,
    output logic                rmst_req,
    output logic [63:0]         rmst_addr,
    output logic [63:0]         rmst_xfer_size,
    input  logic                rmst_done,
    input  logic [c_DATA_W-1:0] s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic [c_DATA_W-1:0] ifm_port,
    output logic                ifm_port_v,
    input  logic                ifm_port_rdy,
    output logic                busy,
    output logic                fetch_done,
    output logic                rd_err
);

    localparam int c_DEPTH = 2 ** FIFO_ADDR_BITS;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [63:0]             r_offset;
    logic [31:0]             r_total;
    logic [31:0]             r_word_idx;
    logic [31:0]             r_len;
    logic [63:0]             r_rmst_addr;
    logic [63:0]             r_xfer_size;
    logic                    r_fetch_done;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic [FIFO_ADDR_BITS:0] w_cnt;
    logic [31:0]             w_remain;
    logic [31:0]             w_len;
    logic [31:0]             w_idx_next;
    logic                    w_space_ok;
    logic                    w_last;
    logic                    w_req;
    logic                    w_busy;

    ifm_rd_fifo #(
        .DATA_W    (c_DATA_W),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_tvalid),
        .push_data (s_tdata),
        .pop       (ifm_port_rdy),
        .head_data (ifm_port),
        .full      (w_full),
        .empty     (w_empty),
        .data_cnt  (w_cnt)
    );

    assign w_push     = s_tvalid & ~w_full;
    assign w_remain   = r_total - r_word_idx;
    assign w_len      = min_u32(w_remain, 32'(BURST_WORDS));
    // Issue only when the whole burst fits, so s_tready never drops mid-burst.
    assign w_space_ok = (34'(w_cnt) + 34'(w_len)) <= 34'(c_DEPTH);
    assign w_idx_next = r_word_idx + r_len;
    assign w_last     = (w_idx_next == r_total);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start_fetch && (total_words != 32'd0)) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_space_ok) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_req       = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (rmst_done) w_state_nxt = w_last ? ST_IDLE : ST_CHECK;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_offset     <= '0;
            r_total      <= '0;
            r_word_idx   <= '0;
            r_len        <= '0;
            r_rmst_addr  <= '0;
            r_xfer_size  <= '0;
            r_fetch_done <= 1'b0;
        end else begin
            r_fetch_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_fetch) begin
                        r_offset     <= rmst_offset;
                        r_total      <= total_words;
                        r_word_idx   <= '0;
                        r_fetch_done <= (total_words == 32'd0);
                    end
                end
                ST_CHECK: begin
                    // Address and size latched here stay frozen through REQ and WAIT.
                    if (w_space_ok) begin
                        r_len       <= w_len;
                        r_rmst_addr <= r_offset + (64'(r_word_idx) * 64'(WORD_BYTE));
                        r_xfer_size <= 64'(w_len) * 64'(WORD_BYTE);
                    end
                end
                ST_WAIT: begin
                    if (rmst_done) begin
                        r_word_idx   <= w_idx_next;
                        r_fetch_done <= w_last;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IFM_READER_BEAT_CHECK_EN
    logic [31:0] r_beat_cnt;
    logic [31:0] w_beats_now;
    logic        r_rd_err;

    // Include a beat landing in the same cycle as rmst_done.
    assign w_beats_now = r_beat_cnt + {31'd0, w_push};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            if (r_state == ST_REQ)  r_beat_cnt <= {31'd0, w_push};
            else if (w_push)        r_beat_cnt <= r_beat_cnt + 32'd1;
            if ((r_state == ST_WAIT) && rmst_done && (w_beats_now != r_len)) r_rd_err <= 1'b1;
        end
    end

    assign rd_err = r_rd_err;
`else
    assign rd_err = 1'b0;
`endif

    assign rmst_req       = w_req;
    assign rmst_addr      = r_rmst_addr;
    assign rmst_xfer_size = r_xfer_size;
    assign s_tready       = ~w_full;
    assign ifm_port_v     = ~w_empty;
    assign busy           = w_busy;
    assign fetch_done     = r_fetch_done;

endmodule : ifm_reader
`default_nettype wire

// File: tb/tb_ifm_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifm_reader
//  Description : Directed self-checking bench for ifm_reader with a small
//                behavioural read master (FIFO depth 4 to exercise stalls).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifm_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_fetch;
    logic [63:0]  rmst_offset;
    logic [31:0]  total_words;
    logic         rmst_req;
    logic [63:0]  rmst_addr;
    logic [63:0]  rmst_xfer_size;
    logic         rmst_done;
    logic [511:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic [511:0] ifm_port;
    logic         ifm_port_v;
    logic         ifm_port_rdy;
    logic         busy;
    logic         fetch_done;
    logic         rd_err;

    int errors = 0;
    int checks = 0;
    bit rm_en = 1'b0;
    bit rm_short = 1'b0;
    int done_cnt = 0;
    logic [63:0]  req_addr_q[$];
    logic [63:0]  req_size_q[$];
    logic [511:0] out_q[$];

    always #5 clk = ~clk;

    ifm_reader #(
        .WORD_BYTE      (64),
        .BURST_WORDS    (2),
        .FIFO_ADDR_BITS (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_fetch    (start_fetch),
        .rmst_offset    (rmst_offset),
        .total_words    (total_words),
        .rmst_req       (rmst_req),
        .rmst_addr      (rmst_addr),
        .rmst_xfer_size (rmst_xfer_size),
        .rmst_done      (rmst_done),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .ifm_port       (ifm_port),
        .ifm_port_v     (ifm_port_v),
        .ifm_port_rdy   (ifm_port_rdy),
        .busy           (busy),
        .fetch_done     (fetch_done),
        .rd_err         (rd_err)
    );

    function automatic logic [511:0] word_of(input logic [63:0] a);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ a[37:6];
        return {16{w}};
    endfunction

    // Passive observer: request log, consumed words, fetch_done pulses.
    always @(negedge clk) begin
        if (rmst_req === 1'b1) begin
            req_addr_q.push_back(rmst_addr);
            req_size_q.push_back(rmst_xfer_size);
        end
        if (ifm_port_v === 1'b1 && ifm_port_rdy === 1'b1 && rst === 1'b0) out_q.push_back(ifm_port);
        if (fetch_done === 1'b1) done_cnt++;
    end

    // Behavioural read master: answers each request with its beats, then rmst_done.
    initial begin : read_master
        logic [63:0] base;
        int nb;
        int n;
        forever begin
            @(negedge clk);
            if (rm_en && rmst_req === 1'b1) begin
                base = rmst_addr;
                nb   = int'(rmst_xfer_size / 64);
                if (rm_short) nb = 1;
                @(posedge clk); #1;
                for (int b = 0; b < nb; b++) begin
                    s_tdata  = word_of(base + 64'(b) * 64);
                    s_tvalid = 1'b1;
                    n = 0;
                    @(negedge clk);
                    while (s_tready !== 1'b1 && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 100) begin
                        checks++;
                        errors++;
                        $display("FAIL rm_tready_timeout got=%b exp=1", s_tready);
                    end
                    @(posedge clk); #1;
                end
                s_tvalid  = 1'b0;
                rmst_done = 1'b1;
                @(posedge clk); #1;
                rmst_done = 1'b0;
            end
        end
    end

    task automatic pulse_start(input logic [63:0] off, input logic [31:0] tot);
        @(posedge clk); #1;
        start_fetch = 1'b1;
        rmst_offset = off;
        total_words = tot;
        @(posedge clk); #1;
        start_fetch = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (fetch_done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (rmst_req === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic clear_logs();
        req_addr_q.delete();
        req_size_q.delete();
        out_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rmst_req !== 1'b0)        begin errors++; $display("FAIL reset_rmst_req got=%b exp=0", rmst_req); end
        checks++; if (rmst_addr !== 64'd0)      begin errors++; $display("FAIL reset_rmst_addr got=%h exp=0", rmst_addr); end
        checks++; if (rmst_xfer_size !== 64'd0) begin errors++; $display("FAIL reset_xfer_size got=%h exp=0", rmst_xfer_size); end
        checks++; if (s_tready !== 1'b1)        begin errors++; $display("FAIL reset_s_tready got=%b exp=1", s_tready); end
        checks++; if (ifm_port_v !== 1'b0)      begin errors++; $display("FAIL reset_ifm_port_v got=%b exp=0", ifm_port_v); end
        checks++; if (busy !== 1'b0)            begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (fetch_done !== 1'b0)      begin errors++; $display("FAIL reset_fetch_done got=%b exp=0", fetch_done); end
        checks++; if (rd_err !== 1'b0)          begin errors++; $display("FAIL reset_rd_err got=%b exp=0", rd_err); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int d0;
        bit ok;
        logic [63:0] ea [3];
        logic [63:0] es [3];
        logic [63:0] ga;
        logic [63:0] gs;
        logic [511:0] gw;
        ea = '{64'h1000, 64'h1080, 64'h1100};
        es = '{64'd128, 64'd128, 64'd64};
        clear_logs();
        d0 = done_cnt;
        rm_en = 1'b1;
        ifm_port_rdy = 1'b1;
        @(posedge clk); #1;
        start_fetch = 1'b1; rmst_offset = 64'h1000; total_words = 32'd5;
        @(posedge clk); #1;
        start_fetch = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy_t1 got=%b exp=1", busy); end
        checks++; if (rmst_req !== 1'b0) begin errors++; $display("FAIL basic_req_t1 got=%b exp=0", rmst_req); end
        @(negedge clk);
        checks++; if (rmst_req !== 1'b1) begin errors++; $display("FAIL basic_req_t2 got=%b exp=1", rmst_req); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got=0 exp=1"); end
        repeat (10) @(negedge clk);
        checks++; if (req_addr_q.size() != 3) begin errors++; $display("FAIL basic_req_count got=%0d exp=3", req_addr_q.size()); end
        for (int i = 0; i < 3; i++) begin
            ga = (i < req_addr_q.size()) ? req_addr_q[i] : '1;
            gs = (i < req_size_q.size()) ? req_size_q[i] : '1;
            checks++; if (ga !== ea[i]) begin errors++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, ga, ea[i]); end
            checks++; if (gs !== es[i]) begin errors++; $display("FAIL basic_size[%0d] got=%0d exp=%0d", i, gs, es[i]); end
        end
        checks++; if (out_q.size() != 5) begin errors++; $display("FAIL basic_word_count got=%0d exp=5", out_q.size()); end
        for (int i = 0; i < 5; i++) begin
            gw = (i < out_q.size()) ? out_q[i] : '0;
            checks++; if (gw !== word_of(64'h1000 + 64'(i) * 64)) begin errors++; $display("FAIL basic_word[%0d] got=%h exp=%h", i, gw[31:0], word_of(64'h1000 + 64'(i) * 64) & 32'hFFFF_FFFF); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_total_zero();
        int d0;
        int r0;
        d0 = done_cnt;
        r0 = req_addr_q.size();
        @(posedge clk); #1;
        start_fetch = 1'b1; rmst_offset = 64'hDEAD_0000; total_words = 32'd0;
        @(negedge clk);
        checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL zero_done_t0 got=%b exp=0", fetch_done); end
        @(posedge clk); #1;
        start_fetch = 1'b0;
        @(negedge clk);
        checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL zero_done_t1 got=%b exp=1", fetch_done); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL zero_busy got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL zero_done_t2 got=%b exp=0", fetch_done); end
        repeat (5) @(negedge clk);
        checks++; if (req_addr_q.size() != r0) begin errors++; $display("FAIL zero_no_req got=%0d exp=%0d", req_addr_q.size(), r0); end
        checks++; if (done_cnt - d0 != 1)      begin errors++; $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [63:0] ga;
        logic [511:0] gw;
        clear_logs();
        rm_en = 1'b1;
        ifm_port_rdy = 1'b0;
        pulse_start(64'h2000, 32'd8);
        repeat (40) @(negedge clk);
        checks++; if (req_addr_q.size() != 2) begin errors++; $display("FAIL bp_stall_req_count got=%0d exp=2", req_addr_q.size()); end
        checks++; if (s_tready !== 1'b0)      begin errors++; $display("FAIL bp_tready got=%b exp=0", s_tready); end
        checks++; if (ifm_port_v !== 1'b1)    begin errors++; $display("FAIL bp_port_v got=%b exp=1", ifm_port_v); end
        checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL bp_busy got=%b exp=1", busy); end
        checks++; if (ifm_port !== word_of(64'h2000)) begin errors++; $display("FAIL bp_head got=%h exp=%h", ifm_port[31:0], word_of(64'h2000) & 32'hFFFF_FFFF); end
        @(posedge clk); #1;
        ifm_port_rdy = 1'b1;
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got=0 exp=1"); end
        repeat (10) @(negedge clk);
        checks++; if (req_addr_q.size() != 4) begin errors++; $display("FAIL bp_req_count got=%0d exp=4", req_addr_q.size()); end
        for (int i = 0; i < 4; i++) begin
            ga = (i < req_addr_q.size()) ? req_addr_q[i] : '1;
            checks++; if (ga !== 64'h2000 + 64'(i) * 128) begin errors++; $display("FAIL bp_addr[%0d] got=%h exp=%h", i, ga, 64'h2000 + 64'(i) * 128); end
        end
        checks++; if (out_q.size() != 8) begin errors++; $display("FAIL bp_word_count got=%0d exp=8", out_q.size()); end
        for (int i = 0; i < 8; i++) begin
            gw = (i < out_q.size()) ? out_q[i] : '0;
            checks++; if (gw !== word_of(64'h2000 + 64'(i) * 64)) begin errors++; $display("FAIL bp_word[%0d] got=%h", i, gw[31:0]); end
        end
    endtask

    task automatic test_ignore_start();
        int d0;
        bit ok;
        logic [63:0] ga;
        logic [511:0] gw;
        clear_logs();
        d0 = done_cnt;
        rm_en = 1'b1;
        ifm_port_rdy = 1'b1;
        pulse_start(64'h3000, 32'd4);
        wait_req(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_req_timeout got=0 exp=1"); end
        @(posedge clk); #1;
        start_fetch = 1'b1; rmst_offset = 64'h9000; total_words = 32'd1;
        @(posedge clk); #1;
        start_fetch = 1'b0;
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_done_timeout got=0 exp=1"); end
        repeat (10) @(negedge clk);
        checks++; if (req_addr_q.size() != 2) begin errors++; $display("FAIL ign_req_count got=%0d exp=2", req_addr_q.size()); end
        for (int i = 0; i < 2; i++) begin
            ga = (i < req_addr_q.size()) ? req_addr_q[i] : '1;
            checks++; if (ga !== 64'h3000 + 64'(i) * 128) begin errors++; $display("FAIL ign_addr[%0d] got=%h exp=%h", i, ga, 64'h3000 + 64'(i) * 128); end
        end
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL ign_word_count got=%0d exp=4", out_q.size()); end
        for (int i = 0; i < 4; i++) begin
            gw = (i < out_q.size()) ? out_q[i] : '0;
            checks++; if (gw !== word_of(64'h3000 + 64'(i) * 64)) begin errors++; $display("FAIL ign_word[%0d] got=%h", i, gw[31:0]); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ign_done_pulses got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_rst_mid_burst();
        bit ok;
        clear_logs();
        rm_en = 1'b0;
        ifm_port_rdy = 1'b0;
        pulse_start(64'h4000, 32'd4);
        wait_req(20, ok);
        checks++; if (!ok || rmst_addr !== 64'h4000) begin errors++; $display("FAIL rst_req1 got=%h exp=4000", rmst_addr); end
        @(posedge clk); #1;
        s_tdata = word_of(64'h4000); s_tvalid = 1'b1;
        @(negedge clk);
        checks++; if (ifm_port_v !== 1'b0) begin errors++; $display("FAIL rst_port_v_same_cycle got=%b exp=0", ifm_port_v); end
        @(posedge clk); #1;
        s_tdata = word_of(64'h4040);
        @(negedge clk);
        checks++; if (ifm_port_v !== 1'b1 || ifm_port !== word_of(64'h4000)) begin errors++; $display("FAIL rst_port_v_next got=%b exp=1", ifm_port_v); end
        @(posedge clk); #1;
        s_tvalid = 1'b0; rmst_done = 1'b1;
        @(posedge clk); #1;
        rmst_done = 1'b0;
        wait_req(20, ok);
        checks++; if (!ok || rmst_addr !== 64'h4080) begin errors++; $display("FAIL rst_req2 got=%h exp=4080", rmst_addr); end
        @(posedge clk); #1;
        s_tdata = word_of(64'h4080); s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got=%b exp=1", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ifm_port_v !== 1'b0) begin errors++; $display("FAIL rst_port_v got=%b exp=0", ifm_port_v); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (rmst_req !== 1'b0)   begin errors++; $display("FAIL rst_req got=%b exp=0", rmst_req); end
        repeat (5) @(negedge clk);
        checks++; if (req_addr_q.size() != 2) begin errors++; $display("FAIL rst_no_more_req got=%0d exp=2", req_addr_q.size()); end
    endtask

    task automatic test_beat_check();
        bit ok;
        clear_logs();
        rm_en = 1'b1;
        ifm_port_rdy = 1'b1;
`ifdef IFM_READER_BEAT_CHECK_EN
        rm_short = 1'b1;
        pulse_start(64'h5000, 32'd2);
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL beat_done_timeout got=0 exp=1"); end
        @(negedge clk);
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL beat_err_set got=%b exp=1", rd_err); end
        repeat (5) @(negedge clk);
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL beat_err_sticky got=%b exp=1", rd_err); end
        rm_short = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL beat_err_cleared got=%b exp=0", rd_err); end
`else
        pulse_start(64'h5000, 32'd2);
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL beat_done_timeout got=0 exp=1"); end
        repeat (5) @(negedge clk);
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL beat_err_tied got=%b exp=0", rd_err); end
        checks++; if (out_q.size() != 2) begin errors++; $display("FAIL beat_word_count got=%0d exp=2", out_q.size()); end
        checks++; if (out_q.size() == 2 && out_q[1] !== word_of(64'h5040)) begin errors++; $display("FAIL beat_word1 got=%h", out_q[1][31:0]); end
`endif
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst          = 1'b1;
        start_fetch  = 1'b0;
        rmst_offset  = '0;
        total_words  = '0;
        rmst_done    = 1'b0;
        s_tdata      = '0;
        s_tvalid     = 1'b0;
        ifm_port_rdy = 1'b0;
        test_reset();
        test_total_zero();
        test_basic();
        test_backpressure();
        test_ignore_start();
        test_rst_mid_burst();
        test_beat_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ifm_reader
`default_nettype wire
